det_engine: RTL and testbench

- Parametrised, mode-selectable determinant engine. It computes the determinant of a 2x2 or 3x3 matrix stored row-major at consecutive addresses of an asynchronous-read ROM.
- It is the generalised successor of the 2x2 determinant calculator and drops into the same top level. ROM address out, ROM data in, start/done handshake.
- A single shared signed multiplier-accumulator evaluates one product term per cycle.

---
 rtl/det_engine.sv | 191 +++++++++++++++++++
 tb/tb_det_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/det_engine.sv
// ---------------------------------------------------------------------------
// det_engine
//   Determinant engine for a 2x2 or 3x3 matrix held row-major at consecutive
//   addresses of an asynchronous-read ROM. The elements are fetched one per
//   cycle into a register file. A single shared multiplier-accumulator then
//   evaluates one signed product term per cycle.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   start             job request, honoured only in IDLE
//   mode              0 = 2x2, 1 = 3x3 (sampled with start)
//   start_address     ROM address of element [0][0] (sampled with start)
//   data_in           ROM read data, combinational from address_to_memory
//   address_to_memory ROM address (wraps modulo 2^ADDR_W)
//   busy              high while loading or calculating
//   done              one-cycle pulse when out becomes valid
//   out               determinant, two's complement, held until next start
// ---------------------------------------------------------------------------
module det_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SIGNED = 1,
    localparam int OUT_W = 3*DATA_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address_to_memory,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]       address_reg;
    logic [3:0]              idx_reg;
    logic [2:0]              term_reg;
    logic                    mode_reg;
    logic signed [OUT_W-1:0] acc_reg;
    logic [OUT_W-1:0]        out_reg;
    logic [DATA_W-1:0]       elem_reg [0:8];

    // Last load index and last term index for the latched mode.
    logic [3:0] n_last;
    logic [2:0] t_last;
    assign n_last = mode_reg ? 4'd8 : 4'd3;
    assign t_last = mode_reg ? 3'd5 : 3'd1;

    // Widen an element to the accumulator width, honouring SIGNED.
    function automatic logic signed [OUT_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0)
            return OUT_W'($signed(v));
        else
            return OUT_W'($signed({1'b0, v}));
    endfunction

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (idx_reg == n_last) state_next = CALC;
            CALC: if (term_reg == t_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Term selection: element indices a..i = 0..8 (row-major).
    // 2x2 uses two-factor terms; the third factor is forced to 1.
    // 3x3 follows the Sarrus order, positive diagonals first.
    // ------------------------------------------------------------------
    logic [3:0] sel_a, sel_b, sel_c;
    logic       use_c;
    logic       negate;

    always_comb begin
        sel_a  = 4'd0;
        sel_b  = 4'd0;
        sel_c  = 4'd0;
        use_c  = 1'b0;
        negate = 1'b0;
        if (!mode_reg) begin
            case (term_reg)
                3'd0:    begin sel_a = 4'd0; sel_b = 4'd3; end
                default: begin sel_a = 4'd1; sel_b = 4'd2; negate = 1'b1; end
            endcase
        end else begin
            use_c = 1'b1;
            case (term_reg)
                3'd0:    begin sel_a = 4'd0; sel_b = 4'd4; sel_c = 4'd8; end
                3'd1:    begin sel_a = 4'd1; sel_b = 4'd5; sel_c = 4'd6; end
                3'd2:    begin sel_a = 4'd2; sel_b = 4'd3; sel_c = 4'd7; end
                3'd3:    begin sel_a = 4'd2; sel_b = 4'd4; sel_c = 4'd6; negate = 1'b1; end
                3'd4:    begin sel_a = 4'd1; sel_b = 4'd3; sel_c = 4'd8; negate = 1'b1; end
                default: begin sel_a = 4'd0; sel_b = 4'd5; sel_c = 4'd7; negate = 1'b1; end
            endcase
        end
    end

    // Shared multiplier-accumulator. OUT_W covers the 3x3 worst case, so
    // truncating the product to OUT_W bits loses nothing.
    logic signed [OUT_W-1:0] f_a, f_b, f_c, prod, acc_next;

    always_comb begin
        f_a      = ext(elem_reg[sel_a]);
        f_b      = ext(elem_reg[sel_b]);
        f_c      = use_c ? ext(elem_reg[sel_c]) : OUT_W'(1);
        prod     = f_a * f_b * f_c;
        acc_next = negate ? (acc_reg - prod) : (acc_reg + prod);
    end

    // ------------------------------------------------------------------
    // Control / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_reg <= '0;
            idx_reg     <= '0;
            term_reg    <= '0;
            mode_reg    <= 1'b0;
            acc_reg     <= '0;
            out_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg    <= mode;
                        address_reg <= start_address;
                        idx_reg     <= '0;
                        term_reg    <= '0;
                        acc_reg     <= '0;
                    end
                end
                LOAD: begin
                    // Address stays on the last element once loading ends.
                    if (idx_reg != n_last) begin
                        idx_reg     <= idx_reg + 4'd1;
                        address_reg <= address_reg + ADDR_W'(1);
                    end
                end
                CALC: begin
                    acc_reg  <= acc_next;
                    term_reg <= term_reg + 3'd1;
                    // Publish on the final term so out is valid with done.
                    if (term_reg == t_last)
                        out_reg <= acc_next;
                end
                default: ;
            endcase
        end
    end

    // Element register file, one register per matrix position.
    for (genvar gi = 0; gi < 9; gi++) begin : g_elem
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                elem_reg[gi] <= '0;
            else if (state_reg == LOAD && idx_reg == 4'(gi))
                elem_reg[gi] <= data_in;
        end
    end

    assign address_to_memory = address_reg;
    assign busy              = (state_reg == LOAD) || (state_reg == CALC);
    assign done              = (state_reg == DONE);
    assign out               = out_reg;

endmodule

// File: tb/tb_det_engine.sv
// ---------------------------------------------------------------------------
// tb_det_engine
//   Directed self-checking bench for det_engine. A signed instance and an
//   unsigned instance share clock, reset and the request inputs. Each one
//   reads its own ROM model.
// ---------------------------------------------------------------------------
module tb_det_engine;

    localparam int OUT_W = 27;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [3:0]       start_address;
    logic [7:0]       rom   [0:15];
    logic [7:0]       rom_u [0:15];

    logic [3:0]       addr,   addr_u;
    logic [7:0]       din,    din_u;
    logic             busy,   busy_u;
    logic             done,   done_u;
    logic [OUT_W-1:0] out,    out_u;

    int tests = 0;
    int fails = 0;
    int addr_seen [0:8];
    int lat;

    always #5 clk = ~clk;

    assign din   = rom[addr];
    assign din_u = rom_u[addr_u];

    det_engine #(.DATA_W(8), .ADDR_W(4), .SIGNED(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .start_address(start_address), .data_in(din),
        .address_to_memory(addr), .busy(busy), .done(done), .out(out)
    );

    det_engine #(.DATA_W(8), .ADDR_W(4), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .start_address(start_address), .data_in(din_u),
        .address_to_memory(addr_u), .busy(busy_u), .done(done_u), .out(out_u)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [OUT_W-1:0] obs, input int exp);
        logic [OUT_W-1:0] e;
        e = OUT_W'(exp);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: got 0x%07h, expected 0x%07h (%0d)", tag, obs, e, exp);
        end
    endtask

    task automatic set_rom(input int a, input int v);
        rom[a[3:0]] = v[7:0];
    endtask

    // Independent reference: cofactor expansion on signed ROM words.
    function automatic int ref_det3(input int base);
        int m [0:8];
        for (int k = 0; k < 9; k++) m[k] = int'($signed(rom[4'(base + k)]));
        return m[0]*(m[4]*m[8] - m[5]*m[7])
             - m[1]*(m[3]*m[8] - m[5]*m[6])
             + m[2]*(m[3]*m[7] - m[4]*m[6]);
    endfunction

    // Called on a falling edge. Issues start and records the address of each
    // cycle after the start edge. Returns when done is seen, or when the
    // 40-cycle budget runs out. lat is the cycle of done relative to the
    // start edge. Optionally it pokes start mid-job and during done.
    task automatic run_job(input logic m, input int base, input int inj_at,
                           input bit inj_done, output int lat_o);
        int l;
        start = 1'b1; mode = m; start_address = base[3:0];
        @(negedge clk);
        start = 1'b0; mode = ~m; start_address = 4'(base + 9);
        l = 0;
        while (1) begin
            if (l < 9) addr_seen[l] = int'(addr);
            if (done || l >= 40) break;
            start = (l == inj_at);
            @(negedge clk);
            l++;
        end
        start = inj_done;
        lat_o = l;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; start_address = '0;
        for (int k = 0; k < 16; k++) begin rom[k] = '0; rom_u[k] = '0; end

        // ---- reset values ----
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_out("rst_out", out, 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(addr), 0);

        // ---- 2x2 basic ----
        set_rom(0, 3); set_rom(1, 5); set_rom(2, 2); set_rom(3, 7);
        run_job(1'b0, 0, -1, 1'b0, lat);
        $display("[TB] 2x2 base0 lat=%0d out=%0d", lat, $signed(out));
        for (int k = 0; k < 4; k++) chk($sformatf("m0_addr%0d", k), addr_seen[k], k);
        chk("m0_lat", lat, 6);
        chk_out("m0_out", out, 11);
        chk("m0_busy_done", int'(busy), 0);
        @(negedge clk);
        chk("m0_done_width", int'(done), 0);

        // ---- 3x3 ----
        set_rom(4, 6);  set_rom(5, 1);  set_rom(6, 1);
        set_rom(7, 4);  set_rom(8, -2); set_rom(9, 5);
        set_rom(10, 2); set_rom(11, 8); set_rom(12, 7);
        run_job(1'b1, 4, -1, 1'b0, lat);
        $display("[TB] 3x3 base4 lat=%0d out=%0d", lat, $signed(out));
        chk("m1_lat", lat, 15);
        chk_out("m1_out", out, -306);
        @(negedge clk);
        chk("m1_done_width", int'(done), 0);

        // ---- start while busy and during done ----
        run_job(1'b1, 4, 3, 1'b1, lat);
        $display("[TB] 3x3 with stray starts lat=%0d out=%0d", lat, $signed(out));
        chk("busy_lat", lat, 15);
        chk_out("busy_out", out, -306);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_done", int'(busy), 0);
        chk("busy_done_width", int'(done), 0);
        run_job(1'b0, 0, -1, 1'b0, lat);
        $display("[TB] 2x2 back-to-back lat=%0d out=%0d", lat, $signed(out));
        chk("b2b_lat", lat, 6);
        chk_out("b2b_out", out, 11);
        @(negedge clk);

        // ---- signed extremes and unsigned build ----
        set_rom(0, -128); set_rom(1, 127); set_rom(2, -128); set_rom(3, -128);
        rom_u[0] = 8'd255; rom_u[1] = 8'd0; rom_u[2] = 8'd0; rom_u[3] = 8'd255;
        run_job(1'b0, 0, -1, 1'b0, lat);
        $display("[TB] extremes lat=%0d out=%0d out_u=%0d", lat, $signed(out), out_u);
        chk_out("ext_out", out, 32640);
        chk_out("uns_out", out_u, 65025);
        chk("uns_done", int'(done_u), 1);
        @(negedge clk);
        set_rom(1, -128);
        run_job(1'b0, 0, -1, 1'b0, lat);
        $display("[TB] all -128 lat=%0d out=%0d", lat, $signed(out));
        chk_out("ext_zero", out, 0);
        @(negedge clk);

        // ---- address wrap ----
        set_rom(14, 2); set_rom(15, -3); set_rom(0, 1);
        set_rom(1, 4);  set_rom(2, 0);   set_rom(3, 5);
        set_rom(4, -1); set_rom(5, 2);   set_rom(6, 3);
        run_job(1'b1, 14, -1, 1'b0, lat);
        $display("[TB] wrap base14 lat=%0d out=%0d", lat, $signed(out));
        for (int k = 0; k < 9; k++)
            chk($sformatf("wrap_addr%0d", k), addr_seen[k], (14 + k) % 16);
        chk_out("wrap_out", out, ref_det3(14));
        @(negedge clk);

        // ---- reset mid-operation ----
        start = 1'b1; mode = 1'b1; start_address = 4'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_busy_before", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        $display("[TB] reset mid-op out=%0d busy=%0d", $signed(out), busy);
        chk_out("mid_out", out, 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_addr", int'(addr), 0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("mid_no_done", seen, 0);
        end
        set_rom(0, 3); set_rom(1, 5); set_rom(2, 2); set_rom(3, 7);
        run_job(1'b0, 0, -1, 1'b0, lat);
        $display("[TB] 2x2 after reset lat=%0d out=%0d", lat, $signed(out));
        chk("post_lat", lat, 6);
        chk_out("post_out", out, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
